road_traffic_mover: RTL and testbench

- Parametrised multi-slot successor of the single-car road mover. Manages N_CARS independent traffic cars on the road strip.
- Each slot has its own lifecycle: release, vertical scroll relative to the player speed, lateral drift for red cars, crash hold on collision, and retirement when off-screen.
- Sits between the traffic spawner (release handshake) and the car sprite/draw blocks (per-slot position and active outputs).

---
 rtl/road_traffic_mover_if.sv | 12 +
 rtl/road_traffic_mover.sv | 184 ++++++++++++++++++
 tb/tb_road_traffic_mover.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/road_traffic_mover_if.sv
// Release handshake between the traffic spawner (master) and road_traffic_mover (slave).
interface road_traffic_mover_if #(
    parameter int POS_W = 11
);
    logic                    rel_valid;
    logic [1:0]              rel_cartype;
    logic signed [POS_W-1:0] rel_x;
    logic                    rel_ready;

    modport master (output rel_valid, output rel_cartype, output rel_x, input rel_ready);
    modport slave  (input rel_valid, input rel_cartype, input rel_x, output rel_ready);
endinterface

// File: rtl/road_traffic_mover.sv
// N_CARS-slot traffic mover: release, scroll, red-car drift, crash hold and retirement.
// Optional pause input enabled by defining ROAD_TRAFFIC_PAUSE_EN.
module road_traffic_mover #(
    parameter int N_CARS       = 4,
    parameter int POS_W        = 11,
    parameter int OBJ_H        = 32,
    parameter int OBJ_W        = 32,
    parameter int FRAME_BOTTOM = 479,
    parameter int BORDER_L     = 215,
    parameter int BORDER_R     = 399,
    parameter int SPD_YELLOW   = 3,
    parameter int SPD_RED      = 2,
    parameter int SPD_TRUCK    = 1,
    parameter int SPD_RIVAL    = 5,
    parameter int DRIFT        = 1,
    parameter int MOVE_DIV     = 1,
    parameter int CRASH_FRAMES = 30
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic [3:0]                playerspeed,
    input  logic [N_CARS-1:0]         collision,
`ifdef ROAD_TRAFFIC_PAUSE_EN
    input  logic                      pause,
`endif
    road_traffic_mover_if.slave       rel,
    output logic [N_CARS-1:0]         active,
    output logic [N_CARS-1:0]         crashed,
    output logic [N_CARS*POS_W-1:0]   topLeftX,
    output logic [N_CARS*POS_W-1:0]   topLeftY
);
    localparam int CNT_W = $clog2(CRASH_FRAMES + 1);

    typedef logic signed [POS_W+1:0] wide_t;
    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_CRASH} state_t;

    state_t                  r_state [N_CARS];
    logic signed [POS_W-1:0] r_x     [N_CARS];
    logic signed [POS_W-1:0] r_y     [N_CARS];
    logic [1:0]              r_type  [N_CARS];
    logic                    r_left  [N_CARS];
    logic [CNT_W-1:0]        r_cnt   [N_CARS];
    logic [3:0]              r_div;

    state_t                  w_state_n [N_CARS];
    logic signed [POS_W-1:0] w_x_n     [N_CARS];
    logic signed [POS_W-1:0] w_y_n     [N_CARS];
    logic [1:0]              w_type_n  [N_CARS];
    logic                    w_left_n  [N_CARS];
    logic [CNT_W-1:0]        w_cnt_n   [N_CARS];
    wide_t                   w_ymov    [N_CARS];
    wide_t                   w_ycrs    [N_CARS];
    wide_t                   w_xdr     [N_CARS];
    logic [N_CARS-1:0]       w_idle;
    logic                    w_pause;
    logic                    w_move;
    logic                    w_accept;
    logic                    w_taken;

`ifdef ROAD_TRAFFIC_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    function automatic wide_t speed_of(input logic [1:0] t);
        case (t)
            2'd0:    speed_of = wide_t'(SPD_YELLOW);
            2'd1:    speed_of = wide_t'(SPD_RED);
            2'd2:    speed_of = wide_t'(SPD_TRUCK);
            default: speed_of = wide_t'(SPD_RIVAL);
        endcase
    endfunction

    function automatic logic off_screen(input wide_t y);
        wide_t bottom_edge;
        bottom_edge = y + wide_t'(OBJ_H);
        return bottom_edge[POS_W+1] || (y > wide_t'(FRAME_BOTTOM));
    endfunction

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_div <= '0;
            for (int unsigned i = 0; i < N_CARS; i++) begin
                r_state[i] <= S_IDLE;
                r_x[i]     <= '0;
                r_y[i]     <= POS_W'(-OBJ_H);
                r_type[i]  <= '0;
                r_left[i]  <= 1'b0;
                r_cnt[i]   <= '0;
            end
        end else begin
            if (startOfFrame && !w_pause)
                r_div <= (r_div == 4'(MOVE_DIV - 1)) ? '0 : r_div + 4'd1;
            for (int unsigned i = 0; i < N_CARS; i++) begin
                r_state[i] <= w_state_n[i];
                r_x[i]     <= w_x_n[i];
                r_y[i]     <= w_y_n[i];
                r_type[i]  <= w_type_n[i];
                r_left[i]  <= w_left_n[i];
                r_cnt[i]   <= w_cnt_n[i];
            end
        end
    end

    always_comb begin
        w_idle = '0;
        for (int unsigned i = 0; i < N_CARS; i++)
            w_idle[i] = (r_state[i] == S_IDLE);
        rel.rel_ready = (|w_idle) && !w_pause;
        w_accept      = rel.rel_valid && rel.rel_ready;
        w_move        = startOfFrame && !w_pause && (r_div == '0);
        // w_taken makes the scan pick only the lowest-index idle slot
        w_taken       = 1'b0;
        for (int unsigned i = 0; i < N_CARS; i++) begin
            w_state_n[i] = r_state[i];
            w_x_n[i]     = r_x[i];
            w_y_n[i]     = r_y[i];
            w_type_n[i]  = r_type[i];
            w_left_n[i]  = r_left[i];
            w_cnt_n[i]   = r_cnt[i];
            w_ymov[i]    = wide_t'(r_y[i]) - speed_of(r_type[i]) + wide_t'(playerspeed);
            w_ycrs[i]    = wide_t'(r_y[i]) + wide_t'(playerspeed);
            w_xdr[i]     = r_left[i] ? wide_t'(r_x[i]) - wide_t'(DRIFT)
                                     : wide_t'(r_x[i]) + wide_t'(DRIFT);
            case (r_state[i])
                S_IDLE: begin
                    if (w_accept && !w_taken) begin
                        w_taken      = 1'b1;
                        w_state_n[i] = S_MOVE;
                        w_x_n[i]     = rel.rel_x;
                        w_y_n[i]     = POS_W'(-OBJ_H);
                        w_type_n[i]  = rel.rel_cartype;
                        w_left_n[i]  = 1'b0;
                    end
                end
                S_MOVE: begin
                    if (collision[i]) begin
                        w_state_n[i] = S_CRASH;
                        w_cnt_n[i]   = CNT_W'(CRASH_FRAMES);
                    end else if (w_move) begin
                        w_y_n[i] = POS_W'(w_ymov[i]);
                        if (off_screen(w_ymov[i]))
                            w_state_n[i] = S_IDLE;
                        if (r_type[i] == 2'd1) begin
                            if (w_xdr[i] <= wide_t'(BORDER_L)) begin
                                w_x_n[i]    = POS_W'(BORDER_L + 1);
                                w_left_n[i] = 1'b0;
                            end else if (w_xdr[i] + wide_t'(OBJ_W) >= wide_t'(BORDER_R)) begin
                                w_x_n[i]    = POS_W'(BORDER_R - OBJ_W - 1);
                                w_left_n[i] = 1'b1;
                            end else begin
                                w_x_n[i] = POS_W'(w_xdr[i]);
                            end
                        end
                    end
                end
                S_CRASH: begin
                    if (w_move) begin
                        w_y_n[i]   = POS_W'(w_ycrs[i]);
                        w_cnt_n[i] = r_cnt[i] - CNT_W'(1);
                        if ((r_cnt[i] == CNT_W'(1)) || off_screen(w_ycrs[i]))
                            w_state_n[i] = S_IDLE;
                    end
                end
                default: w_state_n[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        active   = '0;
        crashed  = '0;
        topLeftX = '0;
        topLeftY = '0;
        for (int unsigned i = 0; i < N_CARS; i++) begin
            active[i]                   = (r_state[i] != S_IDLE);
            crashed[i]                  = (r_state[i] == S_CRASH);
            topLeftX[i*POS_W +: POS_W]  = r_x[i];
            topLeftY[i*POS_W +: POS_W]  = r_y[i];
        end
    end
endmodule

// File: tb/tb_road_traffic_mover.sv
// Self-checking bench for road_traffic_mover: directed vector table, corner sequences, random traffic.
module tb_road_traffic_mover;
    localparam int N  = 4;
    localparam int PW = 11;
    localparam int CF = 3;
    localparam int MDIV = 1;

    logic           clk = 1'b0;
    logic           resetN;
    logic           startOfFrame;
    logic [3:0]     playerspeed;
    logic [N-1:0]   collision;
    logic [N-1:0]   active;
    logic [N-1:0]   crashed;
    logic [N*PW-1:0] topLeftX;
    logic [N*PW-1:0] topLeftY;

    road_traffic_mover_if #(.POS_W(PW)) rel ();

    road_traffic_mover #(
        .N_CARS(N), .POS_W(PW), .MOVE_DIV(MDIV), .CRASH_FRAMES(CF)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .playerspeed(playerspeed),
        .collision(collision),
`ifdef ROAD_TRAFFIC_PAUSE_EN
        .pause(1'b0),
`endif
        .rel(rel),
        .active(active),
        .crashed(crashed),
        .topLeftX(topLeftX),
        .topLeftY(topLeftY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    act;
        logic [N-1:0]    crs;
        logic            rdy;
        logic [N*PW-1:0] x;
        logic [N*PW-1:0] y;
    } exp_t;

    typedef struct {
        logic rst; logic sof; logic [3:0] ps; logic [N-1:0] coll;
        logic rv; logic [1:0] ct; int rx;
        logic [N-1:0] act; logic [N-1:0] crs; logic rdy;
        int x0; int y0; int x1; int y1;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: 0 idle, 1 moving, 2 crashed
    int m_st[N];
    int m_x[N];
    int m_y[N];
    int m_t[N];
    int m_cnt[N];
    bit m_left[N];
    int m_div;

    function automatic int wrap(input int v);
        logic signed [PW-1:0] t;
        t = PW'(v);
        return int'(t);
    endfunction

    function automatic int spd(input int t);
        case (t)
            0: return 3;
            1: return 2;
            2: return 1;
            default: return 5;
        endcase
    endfunction

    task automatic model_reset();
        m_div = 0;
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_x[i] = 0; m_y[i] = -32; m_t[i] = 0; m_cnt[i] = 0; m_left[i] = 0;
        end
    endtask

    task automatic model_edge(input logic rst_n, input logic sof, input logic [3:0] ps,
                              input logic [N-1:0] coll, input logic rv, input logic [1:0] ct, input int rx);
        bit any_free, mv, want;
        int ny, nx, p;
        if (!rst_n) begin
            model_reset();
            return;
        end
        p = ps;
        any_free = 0;
        for (int i = 0; i < N; i++) if (m_st[i] == 0) any_free = 1;
        mv = sof && (m_div == 0);
        if (sof) m_div = (m_div + 1) % MDIV;
        want = rv && any_free;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 0) begin
                if (want) begin
                    m_st[i] = 1; m_x[i] = wrap(rx); m_y[i] = -32; m_t[i] = ct; m_left[i] = 0;
                    want = 0;
                end
            end else if (m_st[i] == 1) begin
                if (coll[i]) begin
                    m_st[i] = 2; m_cnt[i] = CF;
                end else if (mv) begin
                    ny = m_y[i] + p - spd(m_t[i]);
                    if (m_t[i] == 1) begin
                        nx = m_left[i] ? m_x[i] - 1 : m_x[i] + 1;
                        if (nx <= 215) begin m_x[i] = 216; m_left[i] = 0; end
                        else if (nx + 32 >= 399) begin m_x[i] = 366; m_left[i] = 1; end
                        else m_x[i] = nx;
                    end
                    m_y[i] = wrap(ny);
                    if (ny < -32 || ny > 479) m_st[i] = 0;
                end
            end else if (mv) begin
                ny = m_y[i] + p;
                m_y[i] = wrap(ny);
                m_cnt[i]--;
                if (m_cnt[i] == 0 || ny > 479) m_st[i] = 0;
            end
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.rdy = 1'b0;
        for (int i = 0; i < N; i++) begin
            e.act[i] = (m_st[i] != 0);
            e.crs[i] = (m_st[i] == 2);
            if (m_st[i] == 0) e.rdy = 1'b1;
            e.x[i*PW +: PW] = PW'(m_x[i]);
            e.y[i*PW +: PW] = PW'(m_y[i]);
        end
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, want);
        end
    endtask

    task automatic check_out();
        exp_t e;
        e = sb_q.pop_front();
        cmp("active",    64'(active),        64'(e.act));
        cmp("crashed",   64'(crashed),       64'(e.crs));
        cmp("rel_ready", 64'(rel.rel_ready), 64'(e.rdy));
        cmp("topLeftX",  64'(topLeftX),      64'(e.x));
        cmp("topLeftY",  64'(topLeftY),      64'(e.y));
    endtask

    task automatic step(input logic rst_n, input logic sof, input logic [3:0] ps, input logic [N-1:0] coll,
                        input logic rv, input logic [1:0] ct, input int rx, input bit use_tab, input exp_t tab);
        resetN          = rst_n;
        startOfFrame    = sof;
        playerspeed     = ps;
        collision       = coll;
        rel.rel_valid   = rv;
        rel.rel_cartype = ct;
        rel.rel_x       = PW'(rx);
        model_edge(rst_n, sof, ps, coll, rv, ct, rx);
        sb_q.push_back(use_tab ? tab : model_exp());
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic drive(input logic rst_n, input logic sof, input logic [3:0] ps, input logic [N-1:0] coll,
                         input logic rv, input logic [1:0] ct, input int rx);
        exp_t dummy;
        dummy = '{default: '0};
        step(rst_n, sof, ps, coll, rv, ct, rx, 1'b0, dummy);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[13];
        exp_t e;
        model_reset();
        resetN = 1'b0; startOfFrame = 1'b0; playerspeed = '0; collision = '0;
        rel.rel_valid = 1'b0; rel.rel_cartype = '0; rel.rel_x = '0;
        @(posedge clk); #1;

        //          rst sof ps coll rv ct  rx  | act crs rdy  x0   y0   x1   y1
        tab[0]  = '{0, 0, 0, 0, 0, 0, 0,     4'h0, 4'h0, 1, 0,   -32, 0,   -32};
        tab[1]  = '{1, 0, 8, 0, 1, 0, 250,   4'h1, 4'h0, 1, 250, -32, 0,   -32};
        tab[2]  = '{1, 0, 8, 0, 1, 0, 300,   4'h3, 4'h0, 1, 250, -32, 300, -32};
        tab[3]  = '{1, 1, 8, 0, 0, 0, 0,     4'h3, 4'h0, 1, 250, -27, 300, -27};
        tab[4]  = '{1, 1, 8, 0, 0, 0, 0,     4'h3, 4'h0, 1, 250, -22, 300, -22};
        tab[5]  = '{1, 0, 8, 0, 0, 0, 0,     4'h3, 4'h0, 1, 250, -22, 300, -22};
        tab[6]  = '{1, 1, 8, 1, 0, 0, 0,     4'h3, 4'h1, 1, 250, -22, 300, -17};
        tab[7]  = '{1, 1, 4, 0, 0, 0, 0,     4'h3, 4'h1, 1, 250, -18, 300, -16};
        tab[8]  = '{1, 1, 4, 0, 0, 0, 0,     4'h3, 4'h1, 1, 250, -14, 300, -15};
        tab[9]  = '{1, 1, 4, 0, 0, 0, 0,     4'h2, 4'h0, 1, 250, -10, 300, -14};
        tab[10] = '{1, 1, 4, 1, 0, 0, 0,     4'h2, 4'h0, 1, 250, -10, 300, -13};
        tab[11] = '{1, 0, 4, 0, 1, 1, 218,   4'h3, 4'h0, 1, 218, -32, 300, -13};
        tab[12] = '{1, 1, 2, 0, 0, 0, 0,     4'h3, 4'h0, 1, 219, -32, 300, -14};

        for (int v = 0; v < 13; v++) begin
            e.act = tab[v].act;
            e.crs = tab[v].crs;
            e.rdy = tab[v].rdy;
            e.x   = {PW'(0), PW'(0), PW'(tab[v].x1), PW'(tab[v].x0)};
            e.y   = {PW'(-32), PW'(-32), PW'(tab[v].y1), PW'(tab[v].y0)};
            step(tab[v].rst, tab[v].sof, tab[v].ps, tab[v].coll, tab[v].rv, tab[v].ct, tab[v].rx, 1'b1, e);
        end

        // Yellow car scrolled off the bottom
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 15, 0, 1, 0, 250);
        for (int k = 0; k < 120 && m_st[0] != 0; k++) drive(1, k[0], 15, 0, 0, 0, 0);

        // Red car bounces off both road borders
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 2, 0, 1, 1, 360);
        for (int k = 0; k < 170; k++) drive(1, 1, 2, 0, 0, 0, 0);

        // All slots busy, release held until one slot retires
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int s = 0; s < N; s++) begin
            drive(1, 0, 15, 0, 1, 3, 230 + 30 * s);
            repeat (5) drive(1, 1, 15, 0, 0, 0, 0);
        end
        for (int k = 0; k < 60; k++) drive(1, 1, 15, 0, 1, 0, 260);

        // Collision on a frame edge, then reset mid-crash
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 4, 0, 1, 2, 300);
        drive(1, 1, 4, 4'h1, 0, 0, 0);
        drive(1, 1, 4, 0, 0, 0, 0);
        drive(0, 0, 4, 0, 0, 0, 0);
        drive(1, 0, 4, 0, 0, 0, 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] c;
            c = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 15)) : '0;
            drive(($urandom_range(0, 149) != 0), ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), c,
                  ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), $urandom_range(200, 400));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
